// File: rtl/jogo_pkg.sv
// jogo_pkg: state encodings, debug codes and constants shared by the sequence-memory game control unit.
package jogo_pkg;
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        NOVA_SEQ    = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        PERDE_VIDA  = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;
    localparam logic [3:0] DB_INVALIDO = 4'hF;
    localparam int DIV_CURTO = 2;
endpackage

// File: rtl/jogo_contador_timeout.sv
// jogo_contador_timeout: counts cycles while conta is high, flags the last allowed cycle, clears otherwise.
module jogo_contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic conta,
    output logic fim
);
    localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [W-1:0] cnt;
    assign fim = cnt == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset || !conta)
            cnt <= '0;
        else if (!fim)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/jogo_unidade_controle_param.sv
// jogo_unidade_controle_param: Moore control FSM for the sequence-memory game with its own counters.
// Define VIDAS_EN to enable the multi-life retry (perde_vida state and vidas output).
module jogo_unidade_controle_param
    import jogo_pkg::*;
#(
    parameter int N_LEVELS       = 16,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int LIVES          = 3,
    parameter int ADDR_W         = $clog2(N_LEVELS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jogar,
    input  logic              jogada,
    input  logic              igual,
    input  logic              modo,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] nivel,
    output logic              zeraR,
    output logic              registraR,
    output logic              ganhou,
    output logic              perdeu,
    output logic              pronto,
    output logic              deu_timeout,
    output logic [3:0]        vidas,
    output logic [3:0]        db_estado
);
    if (N_LEVELS < 2 || (N_LEVELS & (N_LEVELS - 1)) != 0 || LIVES < 1 || LIVES > 15) begin : g_param_invalido
        $error("jogo_unidade_controle_param: invalid N_LEVELS or LIVES");
    end

    estado_t           estado, prox;
    logic [ADDR_W-1:0] limite;
    logic              fim_tempo;
    logic              perde;

    jogo_contador_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock),
        .reset (reset),
        .conta (estado == ESPERA),
        .fim   (fim_tempo)
    );

`ifdef VIDAS_EN
    logic [3:0] vidas_r;
    assign perde = vidas_r > 4'd1;
    assign vidas = vidas_r;
    always_ff @(posedge clock) begin
        if (reset || estado == PREPARACAO)
            vidas_r <= 4'(LIVES);
        else if (estado == PERDE_VIDA)
            vidas_r <= vidas_r - 4'd1;
    end
`else
    assign perde = 1'b0;
    assign vidas = 4'd0;
`endif

    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL:    prox = jogar ? PREPARACAO : INICIAL;
            PREPARACAO: prox = ESPERA;
            NOVA_SEQ:   prox = ESPERA;
            PROXIMO:    prox = ESPERA;
`ifdef VIDAS_EN
            PERDE_VIDA: prox = ESPERA;
`endif
            ESPERA: begin
                if (jogada)
                    prox = REGISTRA;
                else if (!fim_tempo)
                    prox = ESPERA;
                else if (perde)
                    prox = PERDE_VIDA;
                else
                    prox = FIM_TIMEOUT;
            end
            REGISTRA:   prox = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    prox = perde ? PERDE_VIDA : FIM_ERRO;
                else if (endereco != nivel)
                    prox = PROXIMO;
                else if (nivel == limite)
                    prox = FIM_ACERTO;
                else
                    prox = NOVA_SEQ;
            end
            FIM_ACERTO:  prox = jogar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    prox = jogar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: prox = jogar ? PREPARACAO : FIM_TIMEOUT;
            default:     prox = INICIAL;
        endcase
    end

    // Counters update on the edge that leaves the state that owns the update.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= INICIAL;
            endereco <= '0;
            nivel    <= '0;
            limite   <= ADDR_W'(N_LEVELS - 1);
        end else begin
            estado <= prox;
            case (estado)
                PREPARACAO: begin
                    endereco <= '0;
                    nivel    <= '0;
                    limite   <= modo ? ADDR_W'(N_LEVELS / DIV_CURTO - 1) : ADDR_W'(N_LEVELS - 1);
                end
                NOVA_SEQ: begin
                    nivel    <= nivel + 1'b1;
                    endereco <= '0;
                end
                PROXIMO:    endereco <= endereco + 1'b1;
`ifdef VIDAS_EN
                PERDE_VIDA: endereco <= '0;
`endif
                default: ;
            endcase
        end
    end

    assign zeraR       = estado == INICIAL || estado == PREPARACAO;
    assign registraR   = estado == REGISTRA;
    assign ganhou      = estado == FIM_ACERTO;
    assign perdeu      = estado == FIM_ERRO || estado == FIM_TIMEOUT;
    assign pronto      = estado == FIM_ACERTO || estado == FIM_ERRO || estado == FIM_TIMEOUT;
    assign deu_timeout = estado == FIM_TIMEOUT;

    always_comb begin
        db_estado = DB_INVALIDO;
        case (estado)
            INICIAL, PREPARACAO, NOVA_SEQ, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
            PERDE_VIDA, FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: db_estado = estado;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jogo_unidade_controle_param.sv
// tb_jogo_unidade_controle_param: directed table of game operations with hand-computed states and counters.
module tb_jogo_unidade_controle_param;
    localparam int N = 4, T = 8, L = 2, AW = 2;
`ifdef VIDAS_EN
    localparam logic [3:0] VID = 4'd2;
`else
    localparam logic [3:0] VID = 4'd0;
`endif

    typedef enum int {OP_RESET, OP_START, OP_MOVE, OP_TIMEOUT, OP_LATE} op_t;
    typedef struct {
        op_t        op;
        logic       modo;
        logic       igual;
        logic [3:0] mid;
        logic [3:0] fin;
        logic [1:0] e;
        logic [1:0] n;
        logic [3:0] v;
    } vec_t;

    logic clock = 0, reset = 1, jogar = 0, jogada = 0, igual = 1, modo = 0;
    logic [AW-1:0] endereco, nivel;
    logic zeraR, registraR, ganhou, perdeu, pronto, deu_timeout;
    logic [3:0] vidas, db_estado;

    vec_t tab[64];
    int nt = 0, n_vec = 0, n_err = 0;

    always #5 clock = ~clock;

    jogo_unidade_controle_param #(.N_LEVELS(N), .TIMEOUT_CYCLES(T), .LIVES(L)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .jogada(jogada), .igual(igual), .modo(modo),
        .endereco(endereco), .nivel(nivel), .zeraR(zeraR), .registraR(registraR), .ganhou(ganhou),
        .perdeu(perdeu), .pronto(pronto), .deu_timeout(deu_timeout), .vidas(vidas), .db_estado(db_estado)
    );

    task automatic add(input op_t op, input logic m, input logic g, input logic [3:0] mid,
                       input logic [3:0] fin, input int e, input int n, input logic [3:0] v);
        tab[nt].op = op; tab[nt].modo = m; tab[nt].igual = g; tab[nt].mid = mid;
        tab[nt].fin = fin; tab[nt].e = 2'(e); tab[nt].n = 2'(n); tab[nt].v = v;
        nt++;
    endtask

    task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nome, got, exp);
        end
    endtask

    // {zeraR, registraR, ganhou, perdeu, pronto, deu_timeout} expected in each state
    function automatic logic [5:0] flags(input logic [3:0] s);
        return {s == 4'h0 || s == 4'h1, s == 4'h4, s == 4'hA, s == 4'hE || s == 4'hD,
                s == 4'hA || s == 4'hD || s == 4'hE, s == 4'hD};
    endfunction

    task automatic chk_estado(input string nome, input logic [3:0] s);
        chk({nome, " estado"}, 8'(db_estado), 8'(s));
        chk({nome, " flags"}, 8'({zeraR, registraR, ganhou, perdeu, pronto, deu_timeout}), 8'(flags(s)));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input string nome, input vec_t v);
        chk_estado({nome, " mid"}, v.mid);
        if (v.mid inside {4'h2, 4'h6, 4'h7, 4'h1})
            tick();
        chk_estado(nome, v.fin);
        chk({nome, " endereco"}, 8'(endereco), 8'(v.e));
        chk({nome, " nivel"}, 8'(nivel), 8'(v.n));
        chk({nome, " vidas"}, 8'(vidas), 8'(v.v));
    endtask

    task automatic do_move(input string nome, input vec_t v);
        jogada = 1;
        igual = v.igual;
        tick();
        jogada = 0;
        chk_estado({nome, " registra"}, 4'h4);
        tick();
        chk_estado({nome, " comparacao"}, 4'h5);
        tick();
        settle(nome, v);
    endtask

    initial begin
        // tests 1 and 2: full game then short game, every move correct
        add(OP_RESET, 0, 1, 4'h0, 4'h0, 0, 0, VID);
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, VID);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 1, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, VID);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 2, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 2, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 2, 2, VID);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 3, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 3, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 2, 3, VID);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 3, 3, VID);
        add(OP_MOVE,  0, 1, 4'hA, 4'hA, 3, 3, VID);
        add(OP_START, 1, 1, 4'h1, 4'h3, 0, 0, VID);
        add(OP_MOVE,  1, 1, 4'h2, 4'h3, 0, 1, VID);
        add(OP_MOVE,  1, 1, 4'h6, 4'h3, 1, 1, VID);
        add(OP_MOVE,  1, 1, 4'hA, 4'hA, 1, 1, VID);
`ifdef VIDAS_EN
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 2);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 1, 2);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, 2);
        add(OP_MOVE,  0, 0, 4'h7, 4'h3, 0, 1, 1);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, 1);
        add(OP_MOVE,  0, 0, 4'hE, 4'hE, 1, 1, 1);
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 2);
        add(OP_TIMEOUT, 0, 1, 4'h7, 4'h3, 0, 0, 1);
        add(OP_TIMEOUT, 0, 1, 4'hD, 4'hD, 0, 0, 1);
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 2);
        add(OP_LATE,  0, 1, 4'h2, 4'h3, 0, 1, 2);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, 2);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 2, 2);
        add(OP_TIMEOUT, 0, 1, 4'h7, 4'h3, 0, 2, 1);
        add(OP_RESET, 0, 1, 4'h0, 4'h0, 0, 0, 2);
`else
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 0);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 1, 0);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, 0);
        add(OP_MOVE,  0, 0, 4'hE, 4'hE, 1, 1, 0);
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 0);
        add(OP_TIMEOUT, 0, 1, 4'hD, 4'hD, 0, 0, 0);
        add(OP_START, 0, 1, 4'h1, 4'h3, 0, 0, 0);
        add(OP_LATE,  0, 1, 4'h2, 4'h3, 0, 1, 0);
        add(OP_MOVE,  0, 1, 4'h6, 4'h3, 1, 1, 0);
        add(OP_MOVE,  0, 1, 4'h2, 4'h3, 0, 2, 0);
        add(OP_RESET, 0, 1, 4'h0, 4'h0, 0, 0, 0);
`endif

        repeat (2) tick();
        reset = 0;
        for (int i = 0; i < nt; i++) begin
            string nome;
            nome = $sformatf("v%0d", i);
            case (tab[i].op)
                OP_RESET: begin
                    reset = 1;
                    tick();
                    reset = 0;
                    settle(nome, tab[i]);
                end
                OP_START: begin
                    jogar = 1;
                    modo = tab[i].modo;
                    tick();
                    jogar = 0;
                    settle(nome, tab[i]);
                end
                OP_MOVE: do_move(nome, tab[i]);
                OP_TIMEOUT: begin
                    repeat (T) @(posedge clock);
                    #1;
                    settle(nome, tab[i]);
                end
                OP_LATE: begin
                    repeat (T - 1) @(posedge clock);
                    #1;
                    do_move(nome, tab[i]);
                end
                default: ;
            endcase
        end

        // ignored inputs: jogada in inicial, jogar outside inicial and end states
        jogada = 1;
        tick();
        jogada = 0;
        chk_estado("jogada em inicial", 4'h0);
        jogar = 1;
        modo = 0;
        tick();
        chk_estado("jogar inicial", 4'h1);
        tick();
        chk_estado("jogar preparacao", 4'h3);
        tick();
        chk_estado("jogar em espera", 4'h3);
        jogar = 0;
        tick();
        chk({"espera endereco"}, 8'(endereco), 8'd0);
        chk({"espera vidas"}, 8'(vidas), 8'(VID));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jogo_unidade_controle_param.md
Name: jogo_unidade_controle_param

Overview:
Parametrised control unit for the sequence-memory game. It is the next generation of the fixed-size game FSM and owns its own counters: position, level, timeout and lives. It sits between the top-level game wrapper and the datapath; the datapath supplies `igual` (the play matches the stored entry at `endereco`), and this block drives the register and status controls. New relative to the previous generation: configurable depth and timeout, short/full mode, and a multi-life retry.

Parameters:
- N_LEVELS, 16, maximum sequence length; must be ≥2 and a power of 2.
- TIMEOUT_CYCLES, 5000, clock cycles allowed in espera before a timeout.
- LIVES, 3, attempts per game; range 1..15. Used only with VIDAS_EN.
- ADDR_W, $clog2(N_LEVELS), derived width of the position and level counters.

Ports:
- clock, input, 1: single clock. All state and counters update on the rising edge.
- reset, input, 1: synchronous, active-high.
- jogar, input, 1: start or restart request.
- jogada, input, 1: one-cycle pulse marking a player move.
- igual, input, 1: comparison result from the datapath.
- modo, input, 1: 0 = full game of N_LEVELS levels; 1 = short game of N_LEVELS/2 levels. Sampled in preparacao.
- endereco, output, ADDR_W: current position within the sequence, used as the memory address.
- nivel, output, ADDR_W: current level index; sequence length is nivel+1.
- zeraR, output, 1: clear the play register.
- registraR, output, 1: load the play register.
- ganhou, output, 1: game won.
- perdeu, output, 1: game lost.
- pronto, output, 1: game over.
- deu_timeout, output, 1: game ended by timeout.
- vidas, output, 4: remaining lives.
- db_estado, output, 4: state code for debug display.

Behaviour:
- Moore FSM with registered state. All outputs decode the current state or the counters; no output depends combinationally on inputs.
- Reset (synchronous, takes effect at the next rising edge, including mid-game):
  - state = inicial; endereco = 0; nivel = 0; timeout counter = 0; level limit = N_LEVELS-1; vidas = LIVES.
  - Outputs: zeraR = 1, everything else 0, db_estado = 0.
- States, codes and transitions:
  - inicial (0): jogar → preparacao.
  - preparacao (1): endereco = 0, nivel = 0, vidas = LIVES; latch limit = modo ? N_LEVELS/2-1 : N_LEVELS-1. → espera.
  - nova_seq (2): nivel += 1, endereco = 0. → espera.
  - espera (3): timeout counter increments each cycle; it holds 0 in every other state.
    - jogada → registra. Jogada has priority over a timeout in the same cycle.
    - Else, if counter == TIMEOUT_CYCLES-1 → timeout path.
    - Else stay in espera.
  - registra (4): registraR = 1. → comparacao.
  - comparacao (5):
    - !igual → error path.
    - endereco == nivel and nivel == limit → fim_acerto.
    - endereco == nivel → nova_seq.
    - Otherwise → proximo.
  - proximo (6): endereco += 1. → espera.
  - perde_vida (7): vidas -= 1, endereco = 0, nivel unchanged (the current level is replayed). → espera.
  - fim_acerto (A): pronto = 1, ganhou = 1.
  - fim_erro (E): pronto = 1, perdeu = 1.
  - fim_timeout (D): pronto = 1, perdeu = 1, deu_timeout = 1.
  - From any of the three end states, jogar → preparacao; otherwise hold.
  - Unused encodings → inicial, with db_estado = F.
- Error path and timeout path: if vidas > 1 → perde_vida; else → fim_erro or fim_timeout respectively.
- Counter updates happen on the edge that leaves the named state. Example: endereco changes on the edge from proximo to espera.
- Counters never wrap. endereco ≤ nivel ≤ limit holds by construction.
- zeraR = 1 in inicial and preparacao.
- jogada outside espera is ignored. jogar outside inicial and the end states is ignored.

Optional Feature:
- Macro VIDAS_EN.
- Defined: LIVES and the perde_vida state are active, and vidas reports the remaining lives.
- Undefined: the first error or timeout goes directly to fim_erro or fim_timeout. perde_vida logic is not compiled, and vidas is tied to 0.

Decomposition:
- Package jogo_pkg holds:
  - state encodings and db_estado codes (0–7, A, D, E, F);
  - the localparam for the short-mode divisor.
- One natural sub-module, jogo_contador_timeout, with parameter TIMEOUT_CYCLES:
  - inputs: clock, reset, conta (in espera);
  - output: fim, asserted when count == TIMEOUT_CYCLES-1;
  - the count clears whenever conta = 0.

Test Plan (N_LEVELS=4, TIMEOUT_CYCLES=8, LIVES=2, VIDAS_EN defined):
1. Reset, jogar, modo=0, then igual=1 on every move (10 jogadas in total) → states pass through 2 at nivel 1/2/3, ending in state A with ganhou=1, pronto=1, nivel=3.
2. modo=1, all moves correct → state A after 3 jogadas, with nivel=1 at the end.
3. At nivel=1, endereco=1, drive igual=0 → perde_vida, vidas=1, endereco=0, nivel=1. A second error → state E with perdeu=1.
4. No jogada for 8 cycles in espera → perde_vida. Repeat → state D with deu_timeout=1, perdeu=1. Also: jogada on cycle 7 (the timeout cycle) → registra, with no timeout.
5. Assert reset mid-game at nivel=2 → one edge later state=0, endereco=0, nivel=0, vidas=2, zeraR=1.
6. Rebuild with VIDAS_EN undefined; first error → state E directly, vidas=0.
